i2c_slave_rx: RTL and testbench
===============================

// Module: i2c_slave_rx
// PURPOSE
//  Write-only I2C target that sits downstream of i2c_master on the shared scl/sda bus.
//  Oversamples scl/sda on clk, detects START/STOP, and matches a 7-bit address.
//  ACKs matching write transfers and delivers each received data byte to a local consumer via a valid/ready pulse.
//  Replaces the behavioural ACK model on the bench with synthesizable logic.
// PARAMETERS
//  SLV_ADDR   7'h2D  7-bit target address compared against the first byte after START.
//  SYNC_STG   2      Depth of the scl/sda input synchronizer flops (>=2).
// PORTS
//  clk        in   1  System clock; must be >=16x the scl frequency.
//  rstn       in   1  Asynchronous active-low reset.
//  scl        in   1  I2C clock pin (input only; this block never stretches the clock).
//  sda_in     in   1  I2C data pin, sampled value.
//  sda_oe     out  1  1 = drive sda low (open-drain); 0 = release the line.
//  rx_data    out  8  Last received data byte; valid when rx_valid=1.
//  rx_valid   out  1  One-clk pulse: a byte is accepted.
//  rx_ready   in   1  Consumer can take a byte; sampled in the rx_valid cycle.
//  addr_hit   out  1  High from the address ACK until STOP or repeated START.
//  busy       out  1  High between a detected START and the next STOP.
// BEHAVIOUR
//  Reset values: sda_oe=0, rx_data=8'h00, rx_valid=0, addr_hit=0, busy=0, state=IDLE, bit_cnt=0.
//  Input path: scl and sda each pass through SYNC_STG flops plus one history flop.
//   Edge and condition events are seen SYNC_STG+1 clks after the pin changes.
//  Event definitions (synchronized values):
//   scl_rise / scl_fall: edges of scl.
//   START: sda falls while scl=1.
//   STOP: sda rises while scl=1.
//  Bit timing:
//   Bits are shifted MSB first on scl_rise.
//   sda_oe changes only on scl_fall, one clk after the event.
//  State machine (bit_cnt is 3-bit and wraps 7->0):
//   IDLE: START -> ADDR, bit_cnt=0, busy=1.
//   ADDR: shift on each scl_rise; on the 8th bit, compare byte[7:1] with SLV_ADDR.
//    Match with byte[0]=0 -> A_ACK.
//    Anything else (mismatch or read request) -> IGNORE; sda stays released, i.e. NACK.
//   A_ACK: next scl_fall sets sda_oe=1 and addr_hit=1.
//    The following scl_fall clears sda_oe and enters DATA.
//   DATA: shift 8 bits; after the 8th scl_rise, rx_data=shift_reg and rx_valid pulses for 1 clk.
//    If rx_ready=1 in that clk -> D_ACK.
//    Otherwise rx_valid is still asserted but the byte is dropped, and -> D_NACK.
//   D_ACK: drive ACK over the 9th clock exactly as in A_ACK, then -> DATA for the next byte.
//   D_NACK: leave sda released for the 9th clock, then -> IGNORE.
//   IGNORE: sda_oe=0; wait for STOP or START.
//  Global overrides, from any state:
//   STOP -> IDLE; sda_oe=0, addr_hit=0, busy=0.
//   START (repeated start) -> ADDR; bit_cnt=0, addr_hit=0, sda_oe=0.
//   START/STOP override any bit shift in the same clk.
//   A partially received byte is discarded; rx_valid does not pulse for it.
//  rx_valid never pulses in IDLE, ADDR or IGNORE, and at most once per 9 scl periods.
//  Asynchronous rstn mid-transfer returns everything to reset values immediately.
//   sda is released within the same clk.
//  After reset, no START is recognised until the synchronizers have filled (SYNC_STG+1 clks).
// TESTING
//  T1: START, 0x5A (addr 0x2D, W), 0x11, 0x22, STOP, rx_ready=1.
//   -> ACK on all 3 bytes; rx_valid twice with 0x11 then 0x22; busy/addr_hit fall after STOP.
//  T2: START, 0x5C (addr 0x2E).
//   -> sda_oe stays 0 for the entire transfer, no rx_valid, addr_hit=0.
//  T3: START, 0x5B (addr 0x2D, R).
//   -> NACK; state IGNORE until STOP; no rx_valid.
//  T4: addr ACK, data 0xA5 with rx_ready=0.
//   -> rx_valid pulse with rx_data=0xA5, NACK on the 9th bit; a further byte 0x3C produces no rx_valid.
//  T5: addr ACK, 4 data bits, then repeated START, 0x5A, 0x7E, STOP.
//   -> partial byte dropped; single rx_valid with 0x7E.
//  T6: rstn low while sda_oe=1 during a data ACK.
//   -> sda_oe=0 asynchronously; the next START/0x5A transfer is ACKed normally.

Source files
------------

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: oversampled scl/sda, START/STOP detection, 7-bit address match,
// ACK generation and a valid/ready byte hand-off to a local consumer.
module i2c_slave_rx #(
   parameter logic [6:0]  SLV_ADDR = 7'h2D,
   parameter int unsigned SYNC_STG = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       addr_hit,
   output logic       busy
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StAddr   = 3'd1;
   localparam logic [2:0] StAAck   = 3'd2;
   localparam logic [2:0] StData   = 3'd3;
   localparam logic [2:0] StDAck   = 3'd4;
   localparam logic [2:0] StDNack  = 3'd5;
   localparam logic [2:0] StIgnore = 3'd6;

   localparam int unsigned FILL = SYNC_STG + 1;
   localparam int unsigned FW   = $clog2(FILL + 1);

   // Input synchronizers; reset to the idle-bus level so no false edge follows reset.
   logic [SYNC_STG-1:0] scl_sync_q;
   logic [SYNC_STG-1:0] sda_sync_q;
   logic                scl_h_q;
   logic                sda_h_q;
   logic [FW-1:0]       fill_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_h_q    <= 1'b1;
         sda_h_q    <= 1'b1;
         fill_q     <= '0;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STG-2:0], scl};
         sda_sync_q <= {sda_sync_q[SYNC_STG-2:0], sda_in};
         scl_h_q    <= scl_sync_q[SYNC_STG-1];
         sda_h_q    <= sda_sync_q[SYNC_STG-1];
         if (fill_q != FW'(FILL)) begin
            fill_q <= fill_q + FW'(1);
         end
      end
   end

   logic scl_s;
   logic sda_s;
   logic evt_en;
   logic scl_rise;
   logic scl_fall;
   logic start_evt;
   logic stop_evt;

   always_comb begin
      scl_s     = scl_sync_q[SYNC_STG-1];
      sda_s     = sda_sync_q[SYNC_STG-1];
      evt_en    = (fill_q == FW'(FILL));
      scl_rise  = evt_en &  scl_s & ~scl_h_q;
      scl_fall  = evt_en & ~scl_s &  scl_h_q;
      start_evt = evt_en &  scl_s &  scl_h_q &  sda_h_q & ~sda_s;
      stop_evt  = evt_en &  scl_s &  scl_h_q & ~sda_h_q &  sda_s;
   end

   logic [2:0] state_q,    state_d;
   logic [2:0] bit_cnt_q,  bit_cnt_d;
   logic [6:0] shift_q,    shift_d;
   logic       sda_oe_q,   sda_oe_d;
   logic       ack_ph_q,   ack_ph_d;
   logic [7:0] rx_data_q,  rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       addr_hit_q, addr_hit_d;
   logic       busy_q,     busy_d;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      sda_oe_d   = sda_oe_q;
      ack_ph_d   = ack_ph_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      addr_hit_d = addr_hit_q;
      busy_d     = busy_q;

      if (start_evt) begin
         state_d    = StAddr;
         bit_cnt_d  = 3'd0;
         addr_hit_d = 1'b0;
         sda_oe_d   = 1'b0;
         ack_ph_d   = 1'b0;
         busy_d     = 1'b1;
      end else if (stop_evt) begin
         state_d    = StIdle;
         bit_cnt_d  = 3'd0;
         addr_hit_d = 1'b0;
         sda_oe_d   = 1'b0;
         ack_ph_d   = 1'b0;
         busy_d     = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
            end
            StAddr: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[5:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (shift_q == SLV_ADDR && !sda_s) begin
                        state_d  = StAAck;
                        ack_ph_d = 1'b0;
                     end else begin
                        state_d = StIgnore;
                     end
                  end
               end
            end
            // First fall drives the ACK bit, second fall releases it after the 9th clock.
            StAAck, StDAck: begin
               if (scl_fall) begin
                  if (!ack_ph_q) begin
                     sda_oe_d = 1'b1;
                     ack_ph_d = 1'b1;
                     if (state_q == StAAck) begin
                        addr_hit_d = 1'b1;
                     end
                  end else begin
                     sda_oe_d  = 1'b0;
                     ack_ph_d  = 1'b0;
                     bit_cnt_d = 3'd0;
                     state_d   = StData;
                  end
               end
            end
            StData: begin
               if (rx_valid_q) begin
                  state_d  = rx_ready ? StDAck : StDNack;
                  ack_ph_d = 1'b0;
               end else if (scl_rise) begin
                  shift_d   = {shift_q[5:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     rx_data_d  = {shift_q, sda_s};
                     rx_valid_d = 1'b1;
                  end
               end
            end
            StDNack: begin
               if (scl_fall) begin
                  if (!ack_ph_q) begin
                     ack_ph_d = 1'b1;
                  end else begin
                     ack_ph_d = 1'b0;
                     state_d  = StIgnore;
                  end
               end
            end
            StIgnore: begin
               sda_oe_d = 1'b0;
            end
            default: begin
               state_d  = StIdle;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 7'd0;
         sda_oe_q   <= 1'b0;
         ack_ph_q   <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         addr_hit_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         sda_oe_q   <= sda_oe_d;
         ack_ph_q   <= ack_ph_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         addr_hit_q <= addr_hit_d;
         busy_q     <= busy_d;
      end
   end

   assign sda_oe   = sda_oe_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign addr_hit = addr_hit_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-level I2C master, hand-written vector table, corner sequences
// and randomized transfers checked against a transaction-level model.
module tb_i2c_slave_rx;

   localparam int Q = 6;  // quarter scl period in clk cycles

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       rx_ready = 1'b0;
   logic       scl;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       addr_hit;
   logic       busy;

   assign scl    = scl_m;
   assign sda_in = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_slave_rx #(
      .SLV_ADDR(7'h2D),
      .SYNC_STG(2)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .scl     (scl),
      .sda_in  (sda_in),
      .sda_oe  (sda_oe),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .addr_hit(addr_hit),
      .busy    (busy)
   );

   int checks = 0;
   int failures = 0;

   // Monitor-owned counters; the test reads differences across a transfer.
   int unsigned obs_n = 0;
   int unsigned oe_cnt = 0;
   int unsigned hit_cnt = 0;
   int unsigned busy_cnt = 0;
   logic [7:0]  obs_mem [256];

   always @(negedge clk) begin
      if (rx_valid) begin
         obs_mem[obs_n % 256] = rx_data;
         obs_n = obs_n + 1;
      end
      if (sda_oe) oe_cnt = oe_cnt + 1;
      if (addr_hit) hit_cnt = hit_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation time limit reached, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wq(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic i2c_rstart();
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b1; wq(2 * Q);
   endtask

   task automatic write_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         sda_m = b[i]; wq(Q);
         scl_m = 1'b1; wq(2 * Q);
         scl_m = 1'b0; wq(Q);
      end
   endtask

   task automatic ack_bit(output logic ack);
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      ack = ~sda_in; wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   // Full transfer: START, n bytes (byte 0 = address), STOP; returns what the bus showed.
   task automatic do_txn(input logic [31:0] bytes, input int n, input logic [3:0] rdy,
                         output logic [3:0] acks, output int nv, output logic [31:0] data,
                         output logic oe_any, output logic hit_any);
      int unsigned base, oe0, hit0, busy0;
      logic a;
      base = obs_n; oe0 = oe_cnt; hit0 = hit_cnt; busy0 = busy_cnt;
      acks = 4'b0;
      data = 32'h0;
      i2c_start();
      for (int i = 0; i < n; i++) begin
         rx_ready = rdy[i];
         write_bits(bytes[8*i +: 8], 8);
         ack_bit(a);
         acks[i] = a;
      end
      i2c_stop();
      wq(4);
      nv = int'(obs_n - base);
      for (int k = 0; k < nv && k < 4; k++) data[8*k +: 8] = obs_mem[(base + k) % 256];
      oe_any  = (oe_cnt != oe0);
      hit_any = (hit_cnt != hit0);
      check("busy_seen", 32'(busy_cnt != busy0), 32'd1);
      check("busy_after_stop", 32'(busy), 32'd0);
      check("addr_hit_after_stop", 32'(addr_hit), 32'd0);
   endtask

   // Transaction-level model: which bytes get ACKed and which reach the consumer.
   task automatic model(input logic [31:0] bytes, input int n, input logic [3:0] rdy,
                        output logic [3:0] eacks, output int env, output logic [31:0] edata,
                        output logic addr_ok);
      logic live;
      addr_ok = (bytes[7:1] == 7'h2D) && !bytes[0];
      live = addr_ok;
      eacks = 4'b0;
      eacks[0] = addr_ok;
      env = 0;
      edata = 32'h0;
      for (int i = 1; i < n; i++) begin
         if (live) begin
            edata[8*env +: 8] = bytes[8*i +: 8];
            env++;
            eacks[i] = rdy[i];
            live = rdy[i];
         end
      end
   endtask

   typedef struct packed {
      logic [31:0] bytes;
      logic [2:0]  n;
      logic [3:0]  rdy;
      logic [3:0]  exp_ack;
      logic [2:0]  exp_nv;
      logic [31:0] exp_data;
      logic        exp_oe;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic [3:0]  acks, eacks;
      logic [31:0] data, edata;
      logic        oe_any, hit_any, addr_ok, a0, a1, a2;
      int          nv, env;
      int unsigned base;

      vecs[0] = '{32'h0022_115A, 3'd3, 4'b0110, 4'b0111, 3'd2, 32'h0000_2211, 1'b1};  // T1
      vecs[1] = '{32'h0000_115C, 3'd2, 4'b0010, 4'b0000, 3'd0, 32'h0000_0000, 1'b0};  // T2
      vecs[2] = '{32'h0000_115B, 3'd2, 4'b0010, 4'b0000, 3'd0, 32'h0000_0000, 1'b0};  // T3
      vecs[3] = '{32'h003C_A55A, 3'd3, 4'b0100, 4'b0001, 3'd1, 32'h0000_00A5, 1'b1};  // T4
      vecs[4] = '{32'h8001_FF5A, 3'd4, 4'b1110, 4'b1111, 3'd3, 32'h0080_01FF, 1'b1};
      vecs[5] = '{32'h0000_005A, 3'd1, 4'b0000, 4'b0001, 3'd0, 32'h0000_0000, 1'b1};

      // Reset values.
      wq(3);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_addr_hit", 32'(addr_hit), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rstn = 1'b1;
      wq(10);
      check("idle_busy", 32'(busy), 32'd0);

      for (int v = 0; v < 6; v++) begin
         do_txn(vecs[v].bytes, int'(vecs[v].n), vecs[v].rdy, acks, nv, data, oe_any, hit_any);
         check($sformatf("vec%0d_acks", v), 32'(acks), 32'(vecs[v].exp_ack));
         check($sformatf("vec%0d_nvalid", v), 32'(nv), 32'(vecs[v].exp_nv));
         check($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
         check($sformatf("vec%0d_oe_seen", v), 32'(oe_any), 32'(vecs[v].exp_oe));
         check($sformatf("vec%0d_hit_seen", v), 32'(hit_any), 32'(vecs[v].exp_oe));
         wq(Q);
      end

      // T5: partial data byte cut by a repeated START, then a fresh addressed write.
      base = obs_n;
      i2c_start();
      rx_ready = 1'b1;
      write_bits(8'h5A, 8);
      ack_bit(a0);
      check("t5_hit_before_rs", 32'(addr_hit), 32'd1);
      write_bits(8'hF0, 4);
      i2c_rstart();
      wq(2);
      check("t5_hit_after_rs", 32'(addr_hit), 32'd0);
      check("t5_busy_after_rs", 32'(busy), 32'd1);
      write_bits(8'h5A, 8);
      ack_bit(a1);
      write_bits(8'h7E, 8);
      ack_bit(a2);
      i2c_stop();
      wq(4);
      check("t5_acks", {29'd0, a2, a1, a0}, 32'h7);
      check("t5_nvalid", obs_n - base, 32'd1);
      check("t5_data", 32'(obs_mem[base % 256]), 32'h7E);
      wq(Q);

      // T6: asynchronous reset while the slave is driving a data ACK.
      i2c_start();
      rx_ready = 1'b1;
      write_bits(8'h5A, 8);
      ack_bit(a0);
      write_bits(8'h55, 8);
      sda_m = 1'b1;
      check("t6_oe_before_rst", 32'(sda_oe), 32'd1);
      rstn = 1'b0;
      #1;
      check("t6_oe_in_rst", 32'(sda_oe), 32'd0);
      check("t6_busy_in_rst", 32'(busy), 32'd0);
      check("t6_hit_in_rst", 32'(addr_hit), 32'd0);
      wq(1);
      scl_m = 1'b1; wq(2);
      sda_m = 1'b1; wq(4);
      rstn = 1'b1;
      wq(10);
      do_txn(32'h0000_995A, 2, 4'b0010, acks, nv, data, oe_any, hit_any);
      check("t6_post_acks", 32'(acks), 32'h3);
      check("t6_post_nvalid", 32'(nv), 32'd1);
      check("t6_post_data", data, 32'h99);
      wq(Q);

      // Randomized transfers against the transaction model.
      for (int r = 0; r < 24; r++) begin
         logic [31:0] bytes;
         logic [3:0]  rdy;
         int          n;
         bytes = $urandom;
         case ($urandom_range(0, 5))
            0: bytes[7:0] = 8'h5B;
            1: bytes[7:0] = 8'($urandom_range(0, 255));
            default: bytes[7:0] = 8'h5A;
         endcase
         n = $urandom_range(1, 4);
         for (int i = 0; i < 4; i++) rdy[i] = ($urandom_range(0, 3) != 0);
         do_txn(bytes, n, rdy, acks, nv, data, oe_any, hit_any);
         model(bytes, n, rdy, eacks, env, edata, addr_ok);
         check($sformatf("rnd%0d_acks", r), 32'(acks), 32'(eacks));
         check($sformatf("rnd%0d_nvalid", r), 32'(nv), 32'(env));
         check($sformatf("rnd%0d_data", r), data, edata);
         check($sformatf("rnd%0d_oe_seen", r), 32'(oe_any), 32'(addr_ok));
         check($sformatf("rnd%0d_hit_seen", r), 32'(hit_any), 32'(addr_ok));
         wq($urandom_range(Q, 3 * Q));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
